// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, buffers fetched words with their PC, hands them to decode.
// Optional FETCH_JAL_PREDICT_EN: follow JAL targets at fetch time instead of pc + 4.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          id_ready,
    output logic                          if_valid,
    output logic [31:0]                   if_instr,
    output logic [31:0]                   if_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fetch_occupancy,
    output logic                          misalign_err
);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [0:0]    S_RUN     = 1'b0;
    localparam logic [0:0]    S_FLUSH   = 1'b1;

    logic [31:0]   r_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [0:0]    r_state;
    logic          r_misalign;
    logic [31:0]   r_instr_q [FIFO_DEPTH];
    logic [31:0]   r_pc_q    [FIFO_DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_next_pc;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    // A full buffer blocks the push even when a pop frees a slot this cycle.
    assign w_push  = !w_full && !redirect_valid && (r_state == S_RUN);
    // A redirect flushes the buffer, so a concurrent pop has no effect.
    assign w_pop   = !w_empty && id_ready && !redirect_valid;

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] w_jal_imm;
    assign w_jal_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                        imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign w_next_pc = (imem_rdata[6:0] == 7'b1101111) ? r_pc + w_jal_imm : r_pc + 32'd4;
`else
    assign w_next_pc = r_pc + 32'd4;
`endif

    assign imem_addr       = r_pc;
    assign if_valid        = !w_empty;
    assign if_instr        = w_empty ? NOP_INSTR : r_instr_q[r_head];
    assign if_pc           = w_empty ? 32'h0 : r_pc_q[r_head];
    assign fetch_occupancy = r_count;
    assign misalign_err    = r_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= S_RUN;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_state <= S_FLUSH;
            end else begin
                r_state <= S_RUN;
                if (w_push) begin
                    r_pc   <= w_next_pc;
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop)
                    r_head <= r_head + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_tail] <= imem_rdata;
            r_pc_q[r_tail]    <= r_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_stage;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  fetch_occupancy;
    logic        misalign_err;

    logic [31:0] mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_flush;
    bit          m_mis;

    fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .fetch_occupancy(fetch_occupancy), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[7:2]];

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] imm;
        imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
`ifdef FETCH_JAL_PREDICT_EN
        if (w[6:0] == 7'b1101111) return pc + imm;
`endif
        if (imm == 32'hx) return pc;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = 32'h0;
        m_flush = 0;
        m_mis = 0;
    endtask

    task automatic apply_reset();
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return just after it.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit do_push;
        redirect_valid = rv;
        redirect_pc = rpc;
        id_ready = rdy;
        @(posedge clk);
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            m_flush = 1;
            m_mis = (rpc[1:0] != 2'b00);
        end else begin
            do_push = (q.size() < DEPTH) && !m_flush;
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]]});
                m_pc = model_next_pc(m_pc, mem[m_pc[7:2]]);
            end
            m_flush = 0;
            m_mis = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        #3;
        n_tests++;
        if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_head: valid=%b instr=%h pc=%h, want 0/%h/0", if_valid, if_instr, if_pc, NOP);
        end
        n_tests++;
        if (fetch_occupancy !== 2'd0 || misalign_err !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: occ=%0d mis=%b addr=%h, want 0/0/0", fetch_occupancy, misalign_err, imem_addr);
        end
        apply_reset();
    endtask

    task automatic test_fetch_order();
        apply_reset();
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hfe010113) begin
            n_fail++;
            $display("FAIL first_fetch: valid=%b pc=%h instr=%h, want 1/0/fe010113", if_valid, if_pc, if_instr);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'h4 || if_instr !== 32'h02812623) begin
            n_fail++;
            $display("FAIL second_fetch: pc=%h instr=%h, want 4/02812623", if_pc, if_instr);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (5) cycle(1'b0, 32'h0, 1'b0);
        n_tests++;
        if (fetch_occupancy !== 2'd2 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL full_hold: occ=%0d addr=%h, want 2/8", fetch_occupancy, imem_addr);
        end
        n_tests++;
        if (if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL drain0: pc=%h, want 0", if_pc);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'h4 || fetch_occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL drain1: pc=%h occ=%0d, want 4/1", if_pc, fetch_occupancy);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL drain2: pc=%h, want 8", if_pc);
        end
    endtask

    task automatic test_redirect_and_jal();
        apply_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h48, 1'b1);
        n_tests++;
        if (fetch_occupancy !== 2'd0 || if_valid !== 1'b0 || imem_addr !== 32'h48) begin
            n_fail++;
            $display("FAIL flush: occ=%0d valid=%b addr=%h, want 0/0/48", fetch_occupancy, if_valid, imem_addr);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_gap: valid=%b, want 0", if_valid);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h48 || if_instr !== 32'h0200006f) begin
            n_fail++;
            $display("FAIL redirect_entry: valid=%b pc=%h instr=%h, want 1/48/0200006f", if_valid, if_pc, if_instr);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
`ifdef FETCH_JAL_PREDICT_EN
        if (if_pc !== 32'h68) begin
            n_fail++;
            $display("FAIL jal_next: pc=%h, want 68", if_pc);
        end
`else
        if (if_pc !== 32'h4c) begin
            n_fail++;
            $display("FAIL jal_next: pc=%h, want 4c", if_pc);
        end
`endif
    endtask

    task automatic test_misalign();
        cycle(1'b1, 32'h4a, 1'b1);
        n_tests++;
        if (misalign_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_pulse: got %b, want 1", misalign_err);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear: got %b, want 0", misalign_err);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'h48 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_target: pc=%h mis=%b, want 48/0", if_pc, misalign_err);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'hffff_fffc, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'hffff_fffc) begin
            n_fail++;
            $display("FAIL wrap_top: pc=%h, want fffffffc", if_pc);
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (if_pc !== 32'h0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_zero: pc=%h valid=%b, want 0/1", if_pc, if_valid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h0 || fetch_occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b instr=%h addr=%h occ=%0d, want 0/%h/0/0",
                     if_valid, if_instr, imem_addr, fetch_occupancy, NOP);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            cycle(rv, rpc, 1'($urandom_range(0, 3) != 0));
            exp_pc    = (q.size() > 0) ? q[0].pc : 32'h0;
            exp_instr = (q.size() > 0) ? q[0].instr : NOP;
            n_tests++;
            if (if_valid !== (q.size() > 0) || fetch_occupancy !== 2'(q.size())) begin
                n_fail++;
                $display("FAIL rnd_occ[%0d]: valid=%b occ=%0d, want %0d/%0d", i, if_valid, fetch_occupancy,
                         q.size() > 0, q.size());
            end
            n_tests++;
            if (if_pc !== exp_pc || if_instr !== exp_instr) begin
                n_fail++;
                $display("FAIL rnd_head[%0d]: pc=%h instr=%h, want %h/%h", i, if_pc, if_instr, exp_pc, exp_instr);
            end
            n_tests++;
            if (imem_addr !== m_pc || misalign_err !== m_mis) begin
                n_fail++;
                $display("FAIL rnd_pc[%0d]: addr=%h mis=%b, want %h/%b", i, imem_addr, misalign_err, m_pc, m_mis);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = {$urandom_range(0, 32'h1ff_ffff), 7'b0010011};
        mem[0]  = 32'hfe010113;
        mem[1]  = 32'h02812623;
        mem[18] = 32'h0200006f;
        model_reset();
        test_reset();
        test_fetch_order();
        test_backpressure();
        test_redirect_and_jal();
        test_misalign();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
